// File: rtl/wave_pwm.sv
// PWM stage behind the sine generator: scales each accepted sample by gain and
// plays it as the duty of the next whole PWM period via a one-entry pending buffer.
module wave_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] wave_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [8:0]  gain,
    input  logic        enable,
    output logic        pwm_out,
    output logic        period_start,
    output logic        underrun,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    state_t              state, state_next;
    logic [PWM_BITS-1:0] cnt, cnt_next;
    logic [PWM_BITS-1:0] act_duty, duty_next;
    logic [PWM_BITS-1:0] pend_duty;
    logic                pend_full, pend_full_next;
    logic                start, load, accept, active_next;

    logic [24:0]         prod;
    logic [15:0]         scaled;
    logic [PWM_BITS-1:0] duty_new;

    // Any product bit above bit 23 means the scaled value exceeds 16 bits.
    assign prod     = {9'd0, wave_in} * {16'd0, gain};
    assign scaled   = prod[24] ? 16'hFFFF : prod[23:8];
    assign duty_new = scaled[15 -: PWM_BITS];
    assign accept   = sample_valid && sample_ready;

    // RUN and DRAIN count identically; only the decision at the wrap differs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                    start      = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (cnt == CNT_MAX) begin
                    cnt_next = '0;
                    if (enable) begin
                        state_next = RUN;
                        start      = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next   = cnt + 1'b1;
                    state_next = enable ? RUN : DRAIN;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        load           = start && pend_full;
        duty_next      = load ? pend_duty : act_duty;
        pend_full_next = accept || (pend_full && !load);
        active_next    = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            act_duty     <= '0;
            pend_duty    <= '0;
            pend_full    <= 1'b0;
            sample_ready <= 1'b1;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            act_duty     <= duty_next;
            if (accept) begin
                pend_duty <= duty_new;
            end
            pend_full    <= pend_full_next;
            sample_ready <= !pend_full_next;
            pwm_out      <= active_next && (cnt_next < duty_next);
            period_start <= start;
            underrun     <= start && !pend_full;
            busy         <= active_next;
        end
    end

endmodule

// File: tb/tb_wave_pwm.sv
// Bench for wave_pwm: directed scenarios plus random traffic, all checked every
// cycle against a period-level reference model of the modulator.
module tb_wave_pwm;

    localparam int PWM_BITS = 8;
    localparam int PERIOD   = 1 << PWM_BITS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] waveIn = 16'd0;
    logic        sampleValid = 1'b0;
    logic        sample_ready;
    logic [8:0]  gain = 9'd256;
    logic        enable = 1'b0;
    logic        pwm_out;
    logic        period_start;
    logic        underrun;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wave_pwm #(.PWM_BITS(PWM_BITS)) dut (
        .clk(clk),
        .reset(reset),
        .wave_in(waveIn),
        .sample_valid(sampleValid),
        .sample_ready(sample_ready),
        .gain(gain),
        .enable(enable),
        .pwm_out(pwm_out),
        .period_start(period_start),
        .underrun(underrun),
        .busy(busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Duty a sample will play with, straight from the scaling rule.
    function automatic int scaleDuty(input int wave, input int g);
        int s;
        s = (wave * g) / 256;
        if (s > 65535) s = 65535;
        return s >> (16 - PWM_BITS);
    endfunction

    // Reference model: tracks whether a period is running, which phase is shown,
    // the duty in play and a queue holding at most one waiting duty.
    bit armed = 0;
    bit running = 0;
    int phase = 0;
    int actDuty = 0;
    int pendQ[$];
    bit expPwm = 0, expStart = 0, expUnder = 0, expBusy = 0, expReady = 1;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                armed = 1;
                running = 0;
                phase = 0;
                actDuty = 0;
                pendQ.delete();
                {expPwm, expStart, expUnder, expBusy, expReady} = 5'b00001;
            end else begin
                bit acceptNow;
                bit startNow;
                acceptNow = sampleValid && (pendQ.size() == 0);
                startNow = 0;
                expUnder = 0;
                if (running) begin
                    if (phase == PERIOD - 1) begin
                        if (enable) startNow = 1;
                        else begin
                            running = 0;
                            phase = 0;
                        end
                    end else begin
                        phase++;
                    end
                end else if (enable) begin
                    startNow = 1;
                end
                if (startNow) begin
                    running = 1;
                    phase = 0;
                    if (pendQ.size() > 0) actDuty = pendQ.pop_front();
                    else expUnder = 1;
                end
                if (acceptNow) pendQ.push_back(scaleDuty(int'(waveIn), int'(gain)));
                expPwm   = running && (phase < actDuty);
                expStart = startNow;
                expBusy  = running;
                expReady = (pendQ.size() == 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                checkOutput("outputs{pwm,start,underrun,busy,ready}",
                            int'({pwm_out, period_start, underrun, busy, sample_ready}),
                            int'({expPwm, expStart, expUnder, expBusy, expReady}));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [15:0] w, input logic [8:0] g);
        sampleValid = 1'b1;
        waveIn = w;
        gain = g;
        tick();
        sampleValid = 1'b0;
    endtask

    task automatic waitPeriodStart(output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!period_start && waited < 600);
        if (!period_start) begin
            checks++;
            errors++;
            $display("[TB] FAIL periodStartTimeout: got no period_start after %0d cycles, expected one", waited);
        end
    endtask

    // Counts high cycles over one whole period; leaves the bench on its last phase.
    task automatic measureDuty(input int expDuty, input int expUnd, input string name);
        int waited;
        int highs;
        waitPeriodStart(waited);
        checkOutput({name, "Underrun"}, int'(underrun), expUnd);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            highs += int'(pwm_out);
            if (i < PERIOD - 1) tick();
        end
        checkOutput({name, "HighCycles"}, highs, expDuty);
    endtask

    initial begin
        int waited;
        int n;

        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        checkOutput("idleOutputs", int'({pwm_out, period_start, underrun, busy, sample_ready}), 1);

        applyStimulus(16'h8000, 9'd256);
        enable = 1'b1;
        measureDuty(128, 0, "unityFirst");
        waitPeriodStart(waited);
        checkOutput("unityPeriodSpacing", waited, 1);
        checkOutput("unityRepeatUnderrun", int'(underrun), 1);
        measureDuty(128, 1, "unityThird");

        applyStimulus(16'hC000, 9'd511);
        measureDuty(255, 0, "saturated");
        applyStimulus(16'h4000, 9'd128);
        measureDuty(32, 0, "halfGain");

        sampleValid = 1'b1;
        gain = 9'd256;
        waveIn = 16'($urandom);
        waitPeriodStart(waited);
        for (int p = 0; p < 3; p++) begin
            waveIn = 16'($urandom);
            waitPeriodStart(waited);
            checkOutput("readyAtBoundary", int'(sample_ready), 1);
            tick();
            checkOutput("readyAfterAccept", int'(sample_ready), 0);
        end
        sampleValid = 1'b0;

        waitPeriodStart(waited);
        repeat (50) tick();
        enable = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        checkOutput("drainCyclesToIdle", n, 206);
        checkOutput("drainIdlePwm", int'(pwm_out), 0);

        enable = 1'b1;
        waitPeriodStart(waited);
        checkOutput("restartLatency", waited, 1);
        repeat (20) tick();
        enable = 1'b0;
        repeat (180) tick();
        enable = 1'b1;
        waitPeriodStart(waited);
        checkOutput("drainResumeNoGap", waited, 56);

        waitPeriodStart(waited);
        applyStimulus(16'hFFFF, 9'd256);
        repeat (9) tick();
        reset = 1'b1;
        enable = 1'b0;
        tick();
        checkOutput("resetPwmLow", int'(pwm_out), 0);
        checkOutput("resetBusyLow", int'(busy), 0);
        reset = 1'b0;
        tick();
        checkOutput("resetReady", int'(sample_ready), 1);
        enable = 1'b1;
        measureDuty(0, 1, "afterReset");

        repeat (6000) begin
            sampleValid = ($urandom_range(0, 1) == 1);
            waveIn = 16'($urandom);
            gain = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            reset = ($urandom_range(0, 2999) == 0);
            tick();
        end
        reset = 1'b0;
        sampleValid = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
